// File: rtl/parallel_to_serial_if.sv
// Vector-in / word-out handshake bundle for parallel_to_serial.
// The slave modport is the serializer; master is the surrounding logic.
interface parallel_to_serial_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  logic                   i_valid;
  logic                   o_ready;
  logic [DEPTH*WIDTH-1:0] i_wdata;
  logic                   o_valid;
  logic                   i_ready;
  logic [WIDTH-1:0]       o_rdata;
  logic                   o_last;
  logic                   o_busy;

  modport slave (
    input  i_valid, i_wdata, i_ready,
    output o_ready, o_valid, o_rdata, o_last, o_busy
  );

  modport master (
    output i_valid, i_wdata, i_ready,
    input  o_ready, o_valid, o_rdata, o_last, o_busy
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Parallel-in/serial-out shifter: accepts DEPTH words at once, emits one word per beat,
// word 0 first, with a one-vector pending buffer for gap-free back-to-back streaming.
module parallel_to_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  parallel_to_serial_if.slave bus
);

  localparam int unsigned CntW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [WIDTH-1:0]       sr_q [DEPTH];
  logic [DEPTH*WIDTH-1:0] pend_q;
  logic                   pend_full_q;

  logic accept;
  logic beat;
  logic last_beat;

  assign bus.o_ready = !pend_full_q && !i_rst;
  assign bus.o_valid = (state_q == StShift);
  assign bus.o_rdata = sr_q[0];
  assign bus.o_last  = bus.o_valid && (cnt_q == CntMax);
  assign bus.o_busy  = (state_q == StShift) || pend_full_q;

  assign accept    = bus.i_valid && bus.o_ready;
  assign beat      = bus.o_valid && bus.i_ready;
  assign last_beat = beat && (cnt_q == CntMax);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        sr_q[k] <= '0;
      end
    end else if (last_beat) begin
      cnt_q <= '0;
      if (pend_full_q) begin
        // Swap in the pending vector; a same-cycle accept refills pend.
        for (int k = 0; k < DEPTH; k++) begin
          sr_q[k] <= pend_q[k*WIDTH +: WIDTH];
        end
        if (accept) begin
          pend_q <= bus.i_wdata;
        end
        pend_full_q <= accept;
      end else if (accept) begin
        for (int k = 0; k < DEPTH; k++) begin
          sr_q[k] <= bus.i_wdata[k*WIDTH +: WIDTH];
        end
      end else begin
        // Shifting the final word out leaves sr all zero while idle.
        state_q <= StIdle;
        for (int k = 0; k < DEPTH - 1; k++) begin
          sr_q[k] <= sr_q[k+1];
        end
        sr_q[DEPTH-1] <= '0;
      end
    end else if (beat) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        sr_q[k] <= sr_q[k+1];
      end
      sr_q[DEPTH-1] <= '0;
      cnt_q         <= cnt_q + 1'b1;
      if (accept) begin
        pend_q      <= bus.i_wdata;
        pend_full_q <= 1'b1;
      end
    end else if (accept) begin
      if (state_q == StIdle) begin
        for (int k = 0; k < DEPTH; k++) begin
          sr_q[k] <= bus.i_wdata[k*WIDTH +: WIDTH];
        end
        cnt_q   <= '0;
        state_q <= StShift;
      end else begin
        pend_q      <= bus.i_wdata;
        pend_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial; a word/last scoreboard is checked on every beat.
module tb_parallel_to_serial;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   beats;
  bit   mon_en;

  logic [WIDTH:0] exp_q [$];  // {last, data}

  parallel_to_serial_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  parallel_to_serial #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [DEPTH*WIDTH-1:0] v);
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back({(k == DEPTH - 1) ? 1'b1 : 1'b0, v[k*WIDTH +: WIDTH]});
    end
  endtask

  // Present a vector for one edge; the bench states whether it must be taken.
  task automatic offer(input logic [DEPTH*WIDTH-1:0] v, input bit take);
    bus.i_valid = 1'b1;
    bus.i_wdata = v;
    #1;
    chk("o_ready_at_offer", 64'(bus.o_ready), 64'(take));
    if (take) push_vec(v);
    step();
    bus.i_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    for (n = 0; n < bound && exp_q.size() > 0; n++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor: sampled on the falling edge, ahead of the beat edge.
  always @(negedge clk) begin
    if (mon_en && bus.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(bus.o_rdata), 64'hFFFF_FFFF);
      end else begin
        chk("o_rdata", 64'(bus.o_rdata), 64'(exp_q[0][WIDTH-1:0]));
        chk("o_last", 64'(bus.o_last), 64'(exp_q[0][WIDTH]));
        if (bus.i_ready === 1'b1) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
    end
  end

  initial begin
    int b0;
    checks      = 0;
    errors      = 0;
    beats       = 0;
    mon_en      = 1'b0;
    rst         = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_wdata = 32'h1234_5678;
    bus.i_ready = 1'b1;

    // Reset held two cycles with i_valid high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_o_ready", 64'(bus.o_ready), 64'd0);
    chk("rst_o_rdata", 64'(bus.o_rdata), 64'd0);
    chk("rst_o_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_o_last", 64'(bus.o_last), 64'd0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_o_ready", 64'(bus.o_ready), 64'd1);
    chk("post_rst_o_valid", 64'(bus.o_valid), 64'd0);
    mon_en = 1'b1;
    step();

    // Single vector, words on cycles 1-4, idle on cycle 5.
    offer(32'h4433_2211, 1'b1);
    repeat (4) step();
    @(negedge clk);
    chk("single_idle_o_valid", 64'(bus.o_valid), 64'd0);
    chk("single_idle_o_busy", 64'(bus.o_busy), 64'd0);
    chk("single_all_words", 64'(exp_q.size()), 64'd0);
    step();

    // Backpressure holds 0x22 for three cycles.
    offer(32'h4433_2211, 1'b1);
    step();
    bus.i_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_o_valid", 64'(bus.o_valid), 64'd1);
      chk("bp_hold", 64'(bus.o_rdata), 64'h22);
      step();
    end
    bus.i_ready = 1'b1;
    drain(10);

    // Back-to-back: eight contiguous beats, o_ready low while pend is full.
    offer(32'h4433_2211, 1'b1);
    offer(32'h8877_6655, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("b2b_no_gap", 64'(bus.o_valid), 64'd1);
      chk("b2b_o_ready", 64'(bus.o_ready), (i < 3) ? 64'd0 : 64'd1);
      step();
    end
    @(negedge clk);
    chk("b2b_done", 64'(bus.o_valid), 64'd0);
    chk("b2b_all_words", 64'(exp_q.size()), 64'd0);
    step();

    // Pend full under backpressure; a third offer is ignored.
    b0          = beats;
    bus.i_ready = 1'b0;
    offer(32'h0403_0201, 1'b1);
    offer(32'h0807_0605, 1'b1);
    offer(32'h0C0B_0A09, 1'b0);
    @(negedge clk);
    chk("pend_o_busy", 64'(bus.o_busy), 64'd1);
    step();
    bus.i_ready = 1'b1;
    drain(20);
    step();
    @(negedge clk);
    chk("pend_beats", 64'(beats - b0), 64'd8);
    chk("pend_idle", 64'(bus.o_valid), 64'd0);
    step();

    // Reset mid-stream after the 0x22 beat with pend full.
    offer(32'h4433_2211, 1'b1);
    offer(32'h8877_6655, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_o_valid", 64'(bus.o_valid), 64'd0);
    chk("mid_rst_o_busy", 64'(bus.o_busy), 64'd0);
    step();
    offer(32'hDDCC_BBAA, 1'b1);
    drain(10);
    step();
    @(negedge clk);
    chk("final_idle", 64'(bus.o_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
